cv32e40px_apu_resp_buffer: RTL
==============================

# cv32e40px_apu_resp_buffer

Credit-gated response buffer sitting between the core's APU port and the FP wrapper. It forwards requests to the FPU only while it holds a free result slot. It captures every FPU response (the FPU's output channel has no backpressure) into a small FIFO and returns results and status flags to the core with a valid/ready handshake. This lets the core stall writeback without losing FPU results.

## Interface
- `DEPTH`, default 4: result FIFO entries; power of two, 2..16.
- `OUT_W`, default `$clog2(DEPTH+1)`: width of the outstanding counter (derived; do not override).

- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `core_req_i`  in  1  core APU request
- `core_gnt_o`  out  1  grant to core
- `fpu_req_o`  out  1  request to FP wrapper
- `fpu_gnt_i`  in  1  grant from FP wrapper
- `fpu_rvalid_i`  in  1  FPU result valid (single-cycle pulse, cannot be stalled)
- `fpu_rdata_i`  in  32  FPU result
- `fpu_rflags_i`  in  `APU_NUSFLAGS_CPU` (5)  FPU status flags
- `core_rvalid_o`  out  1  result available to core
- `core_rdata_o`  out  32  result to core
- `core_rflags_o`  out  5  flags to core
- `core_rready_i`  in  1  core accepts result
- `outstanding_o`  out  `OUT_W`  granted ops not yet popped
- `busy_o`  out  1  `outstanding_o != 0`
- `err_o`  out  1  sticky protocol error

## Operation
- Credit: `credit_ok = (outstanding < DEPTH)`.
- Request gating is combinational:
  - `fpu_req_o = core_req_i & credit_ok`
  - `core_gnt_o = fpu_gnt_i & credit_ok`
- Issue event: `fpu_req_o & fpu_gnt_i`.
- Pop event: `core_rvalid_o & core_rready_i`.
- Outstanding counter update: +1 on issue, -1 on pop, unchanged if both occur or neither.
- FIFO:
  - `DEPTH`-entry circular buffer of {rflags, rdata}.
  - Read/write pointers are `log2(DEPTH)` bits and wrap naturally.
  - Occupancy counter width `OUT_W`.
  - Push on `fpu_rvalid_i`; pop on pop event. Simultaneous push and pop leaves occupancy unchanged.
- Outputs from the FIFO:
  - `core_rvalid_o = (occupancy != 0)`.
  - `core_rdata_o` / `core_rflags_o` present the head entry. They are don't-care when empty and are driven as 0 in that case.
- Order: results are delivered to the core in FPU completion order. No reordering.
- Errors; `err_o` sets and stays set until reset on either of:
  - `fpu_rvalid_i` while occupancy == `DEPTH` (push is dropped, FIFO unchanged);
  - `fpu_rvalid_i` while `outstanding == occupancy`, i.e. a response with no in-flight op (push still performed if space).
- Invariant: occupancy ≤ outstanding ≤ `DEPTH`. Under legal FPU behaviour the credit scheme makes overflow impossible.

## Timing
- Reset values: `outstanding_o`=0, `busy_o`=0, `err_o`=0, `core_rvalid_o`=0, `core_rdata_o`=0, `core_rflags_o`=0, pointers=0.
- Request path: zero latency, purely combinational from `core_req_i`, `fpu_gnt_i` and the registered counter.
- Response latency without bypass: `fpu_rvalid_i` in cycle N gives `core_rvalid_o` in cycle N+1.
- Full credit: when `outstanding == DEPTH`, `fpu_req_o`=0 and `core_gnt_o`=0.
  - A pop in cycle N frees a credit visible in cycle N+1. A pop does not combinationally re-enable the request path.
- Reset mid-operation: all state clears immediately (asynchronously). In-flight FPU results arriving after reset release are counted as errors; integration must reset the FPU together with this block.

## Configuration
- Macro `CV32E40PX_APU_RESP_BYPASS_EN`.
- Defined: when the FIFO is empty and `fpu_rvalid_i`=1, the block drives `core_rvalid_o`=1 and `core_rdata_o`/`core_rflags_o` straight from the `fpu_*` inputs in the same cycle.
  - If `core_rready_i`=1, the result is consumed with no FIFO write and the counter decrements.
  - If `core_rready_i`=0, the result is pushed into the FIFO as normal.
- Undefined: no combinational path from `fpu_r*` to `core_r*`; minimum response latency is 1 cycle.

## Test plan
- Reset: assert `rst_ni`=0 mid-burst with 3 entries stored -> all outputs 0 immediately; `outstanding_o`=0 after release.
- Credit stall: `DEPTH`=4, hold `core_rready_i`=0, issue 5 requests with `fpu_gnt_i`=1 -> 4 grants, then `core_gnt_o`=0; `outstanding_o`=4.
  - Pop one -> grant resumes one cycle later.
- Order and data: issue results 0x3F800000/flags 0x00, 0x40000000/0x01, 0x7FC00000/0x10 -> popped in the same order with matching flags.
- Simultaneous push/pop at full occupancy minus one and at wrap-around of the pointers -> occupancy is stable and no data is lost or duplicated.
- Bypass (macro defined): FIFO empty, `fpu_rvalid_i`=1, `core_rready_i`=1, data 0x12345678 -> `core_rvalid_o`=1 and `core_rdata_o`=0x12345678 in the same cycle; occupancy stays 0.
  - Same stimulus with the macro undefined -> data appears 1 cycle later.
- Error: pulse `fpu_rvalid_i` with `outstanding_o`=0 -> `err_o`=1 and it stays set through later traffic until reset.

Source files
------------

// File: rtl/cv32e40px_apu_resp_buffer_if.sv
// Bundle of the core-side APU handshake, the FP wrapper handshake/response channel and the
// buffer's status outputs. Signal names keep their direction suffix as seen from the buffer.
//   slave  : the response buffer itself
//   master : the environment (core + FP wrapper), e.g. a testbench
// Parameters: DEPTH (result FIFO entries), OUT_W (outstanding counter width, derived).
interface cv32e40px_apu_resp_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OUT_W = $clog2(DEPTH + 1)
);
    localparam int unsigned ApuNusflagsCpu = 5;

    logic                      core_req_i;
    logic                      core_gnt_o;
    logic                      fpu_req_o;
    logic                      fpu_gnt_i;
    logic                      fpu_rvalid_i;
    logic [31:0]               fpu_rdata_i;
    logic [ApuNusflagsCpu-1:0] fpu_rflags_i;
    logic                      core_rvalid_o;
    logic [31:0]               core_rdata_o;
    logic [ApuNusflagsCpu-1:0] core_rflags_o;
    logic                      core_rready_i;
    logic [OUT_W-1:0]          outstanding_o;
    logic                      busy_o;
    logic                      err_o;

    modport slave (
        input  core_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, core_rready_i,
        output core_gnt_o, fpu_req_o, core_rvalid_o, core_rdata_o, core_rflags_o,
               outstanding_o, busy_o, err_o
    );

    modport master (
        output core_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, core_rready_i,
        input  core_gnt_o, fpu_req_o, core_rvalid_o, core_rdata_o, core_rflags_o,
               outstanding_o, busy_o, err_o
    );
endinterface

// File: rtl/cv32e40px_apu_resp_buffer.sv
// Credit-gated APU response buffer between the core and the FP wrapper.
// Requests reach the FPU only while a result slot is free; every FPU response (which cannot
// be stalled) is captured into a DEPTH-entry FIFO and handed to the core with valid/ready.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : core req/gnt, FPU req/gnt, FPU response (rvalid/rdata/rflags),
//                   core result (rvalid/rdata/rflags/rready), outstanding_o, busy_o, err_o
// Optional feature: define CV32E40PX_APU_RESP_BYPASS_EN to forward an FPU response straight
// to the core in the same cycle when the FIFO is empty.
module cv32e40px_apu_resp_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OUT_W = $clog2(DEPTH + 1)
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    cv32e40px_apu_resp_buffer_if.slave bus
);
    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned FlagW    = 5;
    localparam int unsigned EntryW   = FlagW + 32;
    localparam logic [OUT_W-1:0] DepthVal = OUT_W'(DEPTH);

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OUT_W-1:0]  occ_q, occ_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;

    logic              credit_ok, empty, full, bypass_hit, rvalid;
    logic              issue, pop, fifo_pop, push, bad_resp;
    logic [EntryW-1:0] head;

    always_comb begin
        credit_ok  = out_q < DepthVal;
        empty      = occ_q == '0;
        full       = occ_q == DepthVal;
        bypass_hit = 1'b0;
`ifdef CV32E40PX_APU_RESP_BYPASS_EN
        bypass_hit = empty & bus.fpu_rvalid_i;
`endif
        rvalid   = ~empty | bypass_hit;
        issue    = bus.core_req_i & credit_ok & bus.fpu_gnt_i;
        pop      = rvalid & bus.core_rready_i;
        fifo_pop = pop & ~bypass_hit;
        // A bypassed response that the core takes immediately never touches the FIFO.
        push     = bus.fpu_rvalid_i & ~full & ~(bypass_hit & bus.core_rready_i);
        // Response into a full FIFO, or with nothing in flight (every granted op already queued).
        bad_resp = bus.fpu_rvalid_i & (full | (out_q == occ_q));

        head = '0;
        if (bypass_hit) begin
            head = {bus.fpu_rflags_i, bus.fpu_rdata_i};
        end else if (!empty) begin
            head = mem_q[rd_ptr_q];
        end

        out_d = out_q;
        if (issue && !pop) begin
            out_d = out_q + OUT_W'(1);
        end else if (pop && !issue && out_q != '0) begin
            // Guarded so a pop of an orphan response cannot wrap the counter.
            out_d = out_q - OUT_W'(1);
        end

        occ_d = occ_q;
        if (push && !fifo_pop) begin
            occ_d = occ_q + OUT_W'(1);
        end else if (fifo_pop && !push) begin
            occ_d = occ_q - OUT_W'(1);
        end

        err_d = err_q | bad_resp;

        bus.fpu_req_o     = bus.core_req_i & credit_ok;
        bus.core_gnt_o    = bus.fpu_gnt_i & credit_ok;
        bus.core_rvalid_o = rvalid;
        bus.core_rdata_o  = head[31:0];
        bus.core_rflags_o = head[EntryW-1:32];
        bus.outstanding_o = out_q;
        bus.busy_o        = out_q != '0;
        bus.err_o         = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            occ_q <= occ_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.fpu_rflags_i, bus.fpu_rdata_i};
        end
    end
endmodule
